// File: rtl/lsu_stage3.sv
// Stage-3 load/store unit: one data-memory transaction per instruction over a
// valid/ready + rvalid bus, with pipeline stall, timeout and load formatting.
module lsu_stage3 #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic        mem_rd_req_in,
    input  logic        mem_wr_req_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    output logic        dmem_req_valid_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wmask_out,
    input  logic        dmem_ready_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        lsu_stall_out,
    output logic        lsu_done_out,
    output logic [31:0] load_data_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_valid_q, req_valid_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic              err_q, err_d;

    logic        req, misaligned, timeout_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    assign req         = (mem_rd_req_in | mem_wr_req_in) & ~flush_in;
    assign misaligned  = (load_size_in == 2'b01 & iadder_in[0]) |
                         (load_size_in[1] & (iadder_in[1:0] != 2'b00));
    // Counter holds the number of REQ/WAIT cycles already spent; this is the last allowed one.
    assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        byte_sel = dmem_rdata_in[7:0];
        case (addr_q[1:0])
            2'd1:    byte_sel = dmem_rdata_in[15:8];
            2'd2:    byte_sel = dmem_rdata_in[23:16];
            2'd3:    byte_sel = dmem_rdata_in[31:24];
            default: byte_sel = dmem_rdata_in[7:0];
        endcase
        half_sel = addr_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (size_q)
            2'b00:   load_fmt = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_fmt = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_fmt = dmem_rdata_in;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_valid_d = req_valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        size_d      = size_q;
        uns_d       = uns_q;
        load_data_d = '0;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && misaligned) begin
                    mis_d = 1'b1;
                end else if (req) begin
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    req_valid_d = 1'b1;
                    we_d        = mem_wr_req_in;
                    addr_d      = iadder_in;
                    size_d      = load_size_in;
                    uns_d       = load_unsigned_in;
                    wdata_d     = '0;
                    wmask_d     = 4'b0000;
                    if (mem_wr_req_in) begin
                        case (load_size_in)
                            2'b00: begin
                                wdata_d = {4{rs2_in[7:0]}};
                                wmask_d = 4'b0001 << iadder_in[1:0];
                            end
                            2'b01: begin
                                wdata_d = {2{rs2_in[15:0]}};
                                wmask_d = 4'b0011 << {iadder_in[1], 1'b0};
                            end
                            default: begin
                                wdata_d = rs2_in;
                                wmask_d = 4'b1111;
                            end
                        endcase
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_ready_in) begin
                    req_valid_d = 1'b0;
                    if (we_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout_hit) begin
                    req_valid_d = 1'b0;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_rvalid_in) begin
                    load_data_d = load_fmt;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:         lsu_stall_out = ~rst_in & req & ~misaligned;
            S_REQ, S_WAIT:  lsu_stall_out = ~rst_in;
            default:        lsu_stall_out = 1'b0;
        endcase
    end

    assign dmem_req_valid_out = req_valid_q;
    assign dmem_we_out        = we_q;
    assign dmem_addr_out      = addr_q;
    assign dmem_wdata_out     = wdata_q;
    assign dmem_wmask_out     = wmask_q;
    assign lsu_done_out       = done_q;
    assign load_data_out      = load_data_q;
    assign misaligned_out     = mis_q;
    assign bus_err_out        = err_q;

endmodule
